regfile_write_arbiter: RTL and testbench

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

---
 rtl/regfile_write_arbiter.sv | 108 ++++++++++
 tb/tb_regfile_write_arbiter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs external unit,
// with starvation forcing and a one-cycle registered write port.
//
// Ports:
//   clk, reset             clock, async active-low reset
//   wb_valid/addr/data     pipeline writeback request, wb_ready accept
//   ext_valid/addr/data    external unit request, ext_ready accept
//   a3/we3/wd3             registered register-file write port
module regfile_write_arbiter #(
    parameter int ADDR_W       = 5,
    parameter int DATA_W       = 19,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              wb_ready,
    input  logic              ext_valid,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_data,
    output logic              ext_ready,
    output logic [ADDR_W-1:0] a3,
    output logic              we3,
    output logic [DATA_W-1:0] wd3
);

    localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

    typedef enum logic {
        NORMAL    = 1'b0,
        FORCE_EXT = 1'b1
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          wb_fire;
    logic          ext_fire;

    // Readies depend only on valids and state, never on addr/data.
    always_comb begin
        wb_ready  = 1'b1;
        ext_ready = 1'b0;
        unique case (state)
            NORMAL: begin
                wb_ready  = 1'b1;
                ext_ready = ~wb_valid;
            end
            FORCE_EXT: begin
                ext_ready = 1'b1;
                wb_ready  = ~ext_valid;
            end
        endcase
    end

    assign wb_fire  = wb_valid & wb_ready;
    assign ext_fire = ext_valid & ext_ready;

    // Counts consecutive denied ext cycles; saturates at the limit.
    always_comb begin
        cnt_nxt = cnt;
        if (!ext_valid || ext_fire)
            cnt_nxt = '0;
        else if (cnt != LIM)
            cnt_nxt = cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= NORMAL;
            cnt   <= '0;
            we3   <= 1'b0;
            a3    <= '0;
            wd3   <= '0;
        end else begin
            cnt <= cnt_nxt;

            unique case (state)
                NORMAL: begin
                    if (cnt_nxt == LIM)
                        state <= FORCE_EXT;
                end
                FORCE_EXT: begin
                    // Leave on the forced transfer or on withdrawal.
                    if (ext_fire || !ext_valid)
                        state <= NORMAL;
                end
            endcase

            // Register 0 is hardwired: handshake completes, no write.
            if (ext_fire) begin
                we3 <= |ext_addr;
                a3  <= ext_addr;
                wd3 <= ext_data;
            end else if (wb_fire) begin
                we3 <= |wb_addr;
                a3  <= wb_addr;
                wd3 <= wb_data;
            end else begin
                we3 <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed testbench for regfile_write_arbiter with an expected-write
// scoreboard and immediate-assertion checks.
module tb_regfile_write_arbiter;

    localparam int AW = 5;
    localparam int DW = 19;

    logic          clk;
    logic          reset;
    logic          wb_valid;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          wb_ready;
    logic          ext_valid;
    logic [AW-1:0] ext_addr;
    logic [DW-1:0] ext_data;
    logic          ext_ready;
    logic [AW-1:0] a3;
    logic          we3;
    logic [DW-1:0] wd3;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    wr_t sb[$];
    int  errors;
    int  checks;

    regfile_write_arbiter #(
        .ADDR_W(AW),
        .DATA_W(DW),
        .STARVE_LIMIT(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .wb_valid(wb_valid),
        .wb_addr(wb_addr),
        .wb_data(wb_data),
        .wb_ready(wb_ready),
        .ext_valid(ext_valid),
        .ext_addr(ext_addr),
        .ext_data(ext_data),
        .ext_ready(ext_ready),
        .a3(a3),
        .we3(we3),
        .wd3(wd3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One arbitration cycle: drive requests, check readies, push the
    // expected write, then compare the registered port after the edge.
    task automatic cycle(input string tag,
                         input logic wv, input logic [AW-1:0] wa,
                         input logic [DW-1:0] wd,
                         input logic ev, input logic [AW-1:0] ea,
                         input logic [DW-1:0] ed,
                         input logic exp_wr, input logic exp_er);
        wr_t e;
        wb_valid  = wv;
        wb_addr   = wa;
        wb_data   = wd;
        ext_valid = ev;
        ext_addr  = ea;
        ext_data  = ed;
        #1;
        chk({tag, ".wb_ready"}, 32'(wb_ready), 32'(exp_wr));
        chk({tag, ".ext_ready"}, 32'(ext_ready), 32'(exp_er));
        if (wv && exp_wr)
            sb.push_back('{we: (wa != 0), a: wa, d: wd});
        else if (ev && exp_er)
            sb.push_back('{we: (ea != 0), a: ea, d: ed});
        else
            sb.push_back('{we: 1'b0, a: '0, d: '0});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, ".sb_empty"}, 32'(1), 32'(0));
        end else begin
            e = sb.pop_front();
            chk({tag, ".we3"}, 32'(we3), 32'(e.we));
            if (e.we) begin
                chk({tag, ".a3"}, 32'(a3), 32'(e.a));
                chk({tag, ".wd3"}, 32'(wd3), 32'(e.d));
            end
        end
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        reset     = 1'b0;
        wb_valid  = 1'b1;
        wb_addr   = 5'd2;
        wb_data   = 19'h4;
        ext_valid = 1'b0;
        ext_addr  = '0;
        ext_data  = '0;

        // Reset holds the write port clear despite a pending request.
        #3;
        chk("rst.we3", 32'(we3), 32'(0));
        chk("rst.a3", 32'(a3), 32'(0));
        chk("rst.wd3", 32'(wd3), 32'(0));
        repeat (2) @(posedge clk);
        #1;
        chk("rst.we3_clk", 32'(we3), 32'(0));
        @(negedge clk);
        reset = 1'b1;
        cycle("first", 1, 5'd2, 19'h4, 0, 5'd0, 19'h0, 1, 0);

        // Collision: wb wins, ext writes on the next cycle.
        cycle("col0", 1, 5'd3, 19'h7, 1, 5'd5, 19'h9, 1, 0);
        cycle("col1", 0, 5'd3, 19'h7, 1, 5'd5, 19'h9, 1, 1);
        cycle("idle", 0, 5'd0, 19'h0, 0, 5'd0, 19'h0, 1, 1);
        chk("hold.a3", 32'(a3), 32'(5));
        chk("hold.wd3", 32'(wd3), 32'(9));

        // Starvation: four wb writes, then ext forced, then wb resumes.
        for (int i = 0; i < 4; i++)
            cycle("starve_wb", 1, AW'(10 + i), DW'(100 + i),
                  1, 5'd6, 19'h1F, 1, 0);
        cycle("starve_ext", 1, 5'd14, 19'h104, 1, 5'd6, 19'h1F, 0, 1);
        cycle("resume", 1, 5'd14, 19'h104, 0, 5'd0, 19'h0, 1, 0);

        // Zero address: accepted but no write.
        cycle("zero", 1, 5'd0, 19'h55, 0, 5'd0, 19'h0, 1, 0);

        // Withdrawal from FORCE_EXT.
        for (int i = 0; i < 4; i++)
            cycle("wd_pre", 1, AW'(16 + i), DW'(200 + i),
                  1, 5'd9, 19'h33, 1, 0);
        cycle("wd_drop", 1, 5'd20, 19'h300, 0, 5'd9, 19'h33, 1, 1);
        // Counter cleared: a full four-cycle wait before forcing again.
        for (int i = 0; i < 4; i++)
            cycle("wd_post", 1, AW'(21 + i), DW'(400 + i),
                  1, 5'd9, 19'h33, 1, 0);
        cycle("wd_force", 1, 5'd25, 19'h500, 1, 5'd9, 19'h33, 0, 1);

        // Mid-stream async reset drops the in-flight write.
        cycle("burst0", 1, 5'd26, 19'h600, 0, 5'd0, 19'h0, 1, 0);
        wb_addr = 5'd27;
        wb_data = 19'h601;
        #2;
        reset = 1'b0;
        #1;
        chk("mid.we3", 32'(we3), 32'(0));
        chk("mid.a3", 32'(a3), 32'(0));
        chk("mid.wd3", 32'(wd3), 32'(0));
        repeat (2) @(posedge clk);
        #1;
        chk("mid.we3_clk", 32'(we3), 32'(0));
        #2;
        reset = 1'b1;
        cycle("after", 1, 5'd7, 19'h77, 0, 5'd0, 19'h0, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
